// File: rtl/pc_ctrl_def.sv
// Purpose: shared definitions for the program-counter controller (state encoding, default widths).
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pc_ctrl_def;

  localparam int PC_W_DEF  = 10;
  localparam int PTR_W_DEF = 10;

  // Controller FSM states; encoding kept explicit so waveforms stay readable.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_next.sv
// Purpose: next-PC arithmetic: absolute target, PC-relative target, or increment.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides whether the result is taken.
module pc_next
  import pc_ctrl_def::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] PC,
  input  logic            BranchEn,
  input  logic            BrAbs,
  input  logic [PC_W-1:0] LutTarget,
  output logic [PC_W-1:0] NextPc
);

  // Relative offsets are two's complement, so a plain modulo add handles
  // backward jumps; every path wraps silently at 2^PC_W.
  always_comb begin
    NextPc = PC + PC_W'(1);
    if (BranchEn) begin
      if (BrAbs) NextPc = LutTarget;
      else       NextPc = PC + LutTarget;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Purpose: program-counter controller FSM (IDLE/RUN/HALTED) with LUT-based branching;
//          optional executed-cycle counter when PC_CTRL_CYCLE_CNT_EN is defined.
// Latency: PC updates one edge after inputs; LutAddr follows BrPtr combinationally.
// Backpressure: Stall freezes PC, state and counter for the cycle.
module pc_ctrl
  import pc_ctrl_def::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int PTR_W = PTR_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             Stall,
  input  logic             BranchEn,
  input  logic             BrAbs,
  input  logic [PTR_W-1:0] BrPtr,
  output logic [PTR_W-1:0] LutAddr,
  input  logic [PC_W-1:0]  LutTarget,
  output logic [PC_W-1:0]  PC,
  output logic             Fetch,
`ifdef PC_CTRL_CYCLE_CNT_EN
  output logic [15:0]      CycleCnt,
`endif
  output logic             Done
);

  pc_state_e       state_d, state_q;
  logic [PC_W-1:0] pc_d, pc_q;
  logic [PC_W-1:0] pc_nxt;

  // The LUT sees the instruction's pointer with no register in between.
  assign LutAddr = BrPtr;

  pc_next #(.PC_W(PC_W)) u_pc_next (
    .PC        (pc_q),
    .BranchEn  (BranchEn),
    .BrAbs     (BrAbs),
    .LutTarget (LutTarget),
    .NextPc    (pc_nxt)
  );

  // Next-state / next-PC: Stall beats Halt beats branch/increment while running.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      ST_RUN: begin
        if (!Stall) begin
          if (Halt) state_d = ST_HALTED;
          else      pc_d    = pc_nxt;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // State and PC registers; reset drops straight back to IDLE at PC 0.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign PC    = pc_q;
  assign Fetch = (state_q == ST_RUN);
  assign Done  = (state_q == ST_HALTED);

`ifdef PC_CTRL_CYCLE_CNT_EN
  logic [15:0] cnt_d, cnt_q;

  // Count every non-stalled RUN cycle (the halt cycle included), saturating;
  // the Start edge into RUN restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != ST_RUN) begin
      if (Start) cnt_d = '0;
    end else if (!Stall && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign CycleCnt = cnt_q;
`endif

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 10, meaning program-counter and LUT target width.
REQ-002 SHALL have parameter PTR_W, default 10, meaning branch-pointer (LUT address) width.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Start  input  1  begin program execution from PC 0.
REQ-006 SHALL have port Halt  input  1  current instruction is halt.
REQ-007 SHALL have port Stall  input  1  freeze PC and state this cycle.
REQ-008 SHALL have port BranchEn  input  1  current instruction is a taken branch.
REQ-009 SHALL have port BrAbs  input  1  1 = absolute target, 0 = PC-relative target.
REQ-010 SHALL have port BrPtr  input  PTR_W  branch pointer from instruction.
REQ-011 SHALL have port LutAddr  output  PTR_W  address driven to LUT.
REQ-012 SHALL have port LutTarget  input  PC_W  target/offset returned combinationally by LUT.
REQ-013 SHALL have port PC  output  PC_W  current program counter.
REQ-014 SHALL have port Fetch  output  1  instruction at PC is valid to execute.
REQ-015 SHALL have port Done  output  1  program halted.
REQ-016 SHALL have port CycleCnt  output  16  executed-cycle count (only with PC_CTRL_CYCLE_CNT_EN).

Function
REQ-017 SHALL implement FSM states IDLE, RUN, HALTED.
REQ-018 SHALL drive LutAddr = BrPtr combinationally in all states (zero latency to LUT).
REQ-019 IDLE: PC held, Fetch=0, Done=0; Start=1 -> RUN next edge with PC=0.
REQ-020 RUN: Fetch=1; per edge, priority Stall > Halt > BranchEn > increment.
REQ-021 RUN, Stall=1: PC, state, counter unchanged; Halt/BranchEn ignored that cycle.
REQ-022 RUN, Halt=1: next state HALTED, PC held at halt instruction address.
REQ-023 RUN, BranchEn=1, BrAbs=1: PC <= LutTarget.
REQ-024 RUN, BranchEn=1, BrAbs=0: PC <= PC + LutTarget modulo 2^PC_W (LutTarget two's complement, 10'h3FF = -1).
REQ-025 RUN, no branch/halt: PC <= PC + 1, wrapping 2^PC_W-1 -> 0 with no flag.
REQ-026 Start while in RUN SHALL be ignored.
REQ-027 HALTED: Fetch=0, Done=1, PC held; Start=1 -> RUN next edge, PC=0, Done=0.
REQ-028 Stall, Halt, BranchEn SHALL be ignored outside RUN.

Reset
REQ-029 Reset low SHALL immediately force state IDLE, PC=0, Fetch=0, Done=0, CycleCnt=0, regardless of clock or current state.
REQ-030 Deassertion SHALL leave block in IDLE until Start.

Configuration
REQ-031 With PC_CTRL_CYCLE_CNT_EN defined, CycleCnt SHALL increment each non-stalled RUN cycle (including halt cycle), saturate at 16'hFFFF, clear to 0 on the Start edge entering RUN.
REQ-032 Without PC_CTRL_CYCLE_CNT_EN, CycleCnt port and counter logic SHALL be absent.

Structure
REQ-033 Shared package pc_ctrl_def SHALL hold the FSM state enum and PC_W/PTR_W default constants.
REQ-034 Next-PC arithmetic SHALL be one combinational sub-module pc_next (inputs PC, BranchEn, BrAbs, LutTarget; output next PC).

Verification
REQ-035 Reset low mid-RUN at PC=0x025 -> PC=0, IDLE, Fetch=0 before next edge.
REQ-036 Start pulse, 5 plain cycles -> PC 0,1,2,3,4,5; Fetch=1 throughout.
REQ-037 PC=0x010, BranchEn=1, BrAbs=0, LutTarget=0x3FF -> PC=0x00F; BrAbs=1, LutTarget=0x003 -> PC=0x003.
REQ-038 PC=0x3FF plain cycle -> PC=0x000; PC=0x3FE, relative LutTarget=0x005 -> PC=0x003.
REQ-039 Stall=1 with Halt=1 and BranchEn=1 at PC=0x007 -> PC stays 0x007, state RUN; next cycle Halt=1 -> HALTED, Done=1, PC=0x007.
REQ-040 HALTED, Start pulse -> RUN, PC=0, Done=0; with PC_CTRL_CYCLE_CNT_EN, CycleCnt=0 then counts 1,2,3.
